maxunpool_stream: RTL

//   Inverse of the 2x2/stride-2 max-pool stage: rebuilds a full-resolution map from pooled

---
 rtl/maxunpool_stream.sv | 132 +++++++++++++
 1 files changed

// File: rtl/maxunpool_stream.sv
// Streaming 2x2/stride-2 max-unpool: buffers one pooled row of {value, argmax},
// then emits the two full-resolution output rows it expands to, zero-filling non-argmax slots.
`timescale 1ns/1ps
module maxunpool_stream #(
    parameter int OUT_HEIGHT = 128,
    parameter int OUT_WIDTH  = 128,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_idx,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_row_end,
    output logic                  out_frame_end,
    output logic                  done_unpool
);
    localparam int IN_H = OUT_HEIGHT / 2;
    localparam int IN_W = OUT_WIDTH / 2;
    localparam int ICW  = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int OCW  = (OUT_WIDTH > 2) ? $clog2(OUT_WIDTH) : 1;
    localparam int RW   = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [ICW-1:0] ICOL_LAST = ICW'(IN_W - 1);
    localparam logic [OCW-1:0] OCOL_LAST = OCW'(OUT_WIDTH - 1);
    localparam logic [RW-1:0]  PROW_LAST = RW'(IN_H - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FILL     = 3'd1,
        S_EMIT_TOP = 3'd2,
        S_EMIT_BOT = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [ICW-1:0]        icol_r;
    logic [OCW-1:0]        ocol_r;
    logic [RW-1:0]         prow_r;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] line_data_r [IN_W];
    logic [1:0]            line_idx_r  [IN_W];

    logic                  in_hs_s;
    logic                  out_hs_s;
    logic                  emit_s;
    logic                  ocol_last_s;
    logic                  prow_last_s;
    logic [ICW-1:0]        rd_col_s;
    logic [1:0]            slot_s;

    assign emit_s        = (state_r == S_EMIT_TOP) || (state_r == S_EMIT_BOT);
    assign in_ready      = (state_r == S_FILL);
    assign out_valid     = emit_s;
    assign in_hs_s       = in_valid && in_ready;
    assign out_hs_s      = out_valid && out_ready;
    assign ocol_last_s   = (ocol_r == OCOL_LAST);
    assign prow_last_s   = (prow_r == PROW_LAST);
    assign out_row_end   = emit_s && ocol_last_s;
    assign out_frame_end = (state_r == S_EMIT_BOT) && ocol_last_s && prow_last_s;
    assign done_unpool   = done_r;
    assign rd_col_s      = ICW'(ocol_r >> 1);
    assign slot_s        = {(state_r == S_EMIT_BOT), ocol_r[0]};

    // Frame sequencing: fill a pooled row, emit its top and bottom output rows.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (en) state_s = S_FILL;
                else    state_s = S_IDLE;
            end
            S_FILL: begin
                if (in_hs_s && (icol_r == ICOL_LAST)) state_s = S_EMIT_TOP;
                else                                  state_s = S_FILL;
            end
            S_EMIT_TOP: begin
                if (out_hs_s && ocol_last_s) state_s = S_EMIT_BOT;
                else                         state_s = S_EMIT_TOP;
            end
            S_EMIT_BOT: begin
                if (out_hs_s && ocol_last_s) state_s = prow_last_s ? S_DONE : S_FILL;
                else                         state_s = S_EMIT_BOT;
            end
            S_DONE: begin
                if (en) state_s = S_FILL;
                else    state_s = S_DONE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output pixel: the pooled value only in its argmax slot of the 2x2 block.
    always_comb begin
        out_data = '0;
        if (emit_s && (line_idx_r[rd_col_s] == slot_s)) out_data = line_data_r[rd_col_s];
        else                                            out_data = '0;
    end

    // State, column/row counters and the sticky done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            icol_r  <= '0;
            ocol_r  <= '0;
            prow_r  <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == S_DONE);
            if (in_hs_s) icol_r <= (icol_r == ICOL_LAST) ? '0 : icol_r + ICW'(1);
            if (out_hs_s) ocol_r <= ocol_last_s ? '0 : ocol_r + OCW'(1);
            if (((state_r == S_IDLE) || (state_r == S_DONE)) && en)
                prow_r <= '0;
            else if ((state_r == S_EMIT_BOT) && out_hs_s && ocol_last_s && !prow_last_s)
                prow_r <= prow_r + RW'(1);
        end
    end

    // Line buffer holds one pooled row; contents need no reset.
    always_ff @(posedge clk) begin
        if (in_hs_s) begin
            line_data_r[icol_r] <= in_data;
            line_idx_r[icol_r]  <= in_idx;
        end
    end
endmodule
